// File: rtl/shift_in8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_in8_pkg
//  Description : Shared constants for the shift_in8 serial-to-parallel
//                byte collector and its shift register.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_in8_pkg;

    // Width of one collected byte.
    localparam int BYTE_W = 8;

    // Width of the bit counter (0..BYTE_W-1).
    localparam int CNT_W  = 3;

endpackage : shift_in8_pkg
`default_nettype wire

// File: rtl/shift_reg8.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg8
//  Description : 8-bit shift register with enable, run-time direction select
//                and synchronous clear.
//  Ports       : clk         - clock, rising edge
//                rst         - synchronous active-high reset
//                i_clr       - synchronous clear (same effect as rst)
//                i_en        - shift enable, one bit accepted per cycle
//                i_msb_first - 1: shift left, new bit enters bit 0
//                              0: shift right, new bit enters bit 7
//                i_bit       - serial bit shifted in when i_en=1
//                o_shifted   - value the register holds after this
//                              cycle's shift, including i_bit
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_reg8
    import shift_in8_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic              i_msb_first,
    input  logic              i_bit,
    output logic [BYTE_W-1:0] o_shifted
);

    logic [BYTE_W-1:0] r_sr;
    logic [BYTE_W-1:0] w_shifted;

    // The shifted value is exported so the caller can capture a completed
    // byte on the same edge that accepts its last bit.
    always_comb begin
        w_shifted = r_sr;
        if (i_msb_first) begin
            w_shifted = {r_sr[BYTE_W-2:0], i_bit};
        end else begin
            w_shifted = {i_bit, r_sr[BYTE_W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_sr <= '0;
        end else if (i_en) begin
            r_sr <= w_shifted;
        end
    end

    assign o_shifted = w_shifted;

endmodule : shift_reg8
`default_nettype wire

// File: rtl/shift_in8.sv
`default_nettype none
// ============================================================================
//  Module      : shift_in8
//  Description : Serial-to-parallel byte collector with a one-byte holding
//                register, valid/ready output handshake, sticky overrun flag
//                and an "any bit set" flag from an 8-way OR gate.
//  Ports       : clk       - clock, rising edge
//                reset     - synchronous active-high reset
//                sin       - serial data bit
//                sin_en    - bit strobe
//                clear     - synchronous abort of partial byte, clears overrun
//                out       - holding register (completed byte)
//                out_valid - holding register has an unconsumed byte
//                out_ready - consumer accepts out when out_valid & out_ready
//                overrun   - sticky: a completed byte was dropped
//                nonzero   - OR of all bits of out (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_in8
    import shift_in8_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              sin,
    input  logic              sin_en,
    input  logic              clear,
    output logic [BYTE_W-1:0] out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    output logic              nonzero
);

    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(BYTE_W - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic [BYTE_W-1:0] r_out;
    logic              r_out_valid;
    logic              r_overrun;

    logic [BYTE_W-1:0] w_byte;
    logic              w_shift;
    logic              w_complete;
    logic              w_handshake;
    wire               w_nonzero;

    // clear outranks sin_en, so a strobe in a clear cycle is discarded.
    assign w_shift     = sin_en & ~clear;
    assign w_complete  = w_shift & (r_cnt == C_LAST_BIT);
    assign w_handshake = r_out_valid & out_ready;

    shift_reg8 u_shift_reg8 (
        .clk         (clk),
        .rst         (reset),
        .i_clr       (clear),
        .i_en        (w_shift),
        .i_msb_first (MSB_FIRST),
        .i_bit       (sin),
        .o_shifted   (w_byte)
    );

    // Bit counter wraps naturally from 7 to 0 on byte completion.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (w_shift) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Holding register and valid flag. The handshake is independent of
    // clear; a completion coinciding with a handshake reloads without a
    // bubble in out_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_complete && (!r_out_valid || w_handshake)) begin
            r_out       <= w_byte;
            r_out_valid <= 1'b1;
        end else if (w_handshake) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_overrun <= 1'b0;
        end else if (w_complete && r_out_valid && !w_handshake) begin
            r_overrun <= 1'b1;
        end
    end

    // Any-bit-set flag from the downstream 8-way OR gate.
    or u_or8 (w_nonzero, r_out[0], r_out[1], r_out[2], r_out[3],
                         r_out[4], r_out[5], r_out[6], r_out[7]);

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;
    assign nonzero   = w_nonzero;

endmodule : shift_in8
`default_nettype wire

// File: tb/tb_shift_in8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_in8
//  Description : Self-checking bench for shift_in8. Two instances (MSB-first
//                and LSB-first) share the same stimulus; every consumed byte
//                is compared against a queue of hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_in8;

    logic       clk = 1'b0;
    logic       reset;
    logic       sin;
    logic       sin_en;
    logic       clear;
    logic       out_ready;

    logic [7:0] m_out,     l_out;
    logic       m_valid,   l_valid;
    logic       m_overrun, l_overrun;
    logic       m_nonzero, l_nonzero;

    int         n_tests = 0;
    int         n_fail  = 0;

    logic [7:0] q_m[$];
    logic [7:0] q_l[$];

    always #5 clk = ~clk;

    shift_in8 #(.MSB_FIRST(1'b1)) dut_msb (
        .clk       (clk),
        .reset     (reset),
        .sin       (sin),
        .sin_en    (sin_en),
        .clear     (clear),
        .out       (m_out),
        .out_valid (m_valid),
        .out_ready (out_ready),
        .overrun   (m_overrun),
        .nonzero   (m_nonzero)
    );

    shift_in8 #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .reset     (reset),
        .sin       (sin),
        .sin_en    (sin_en),
        .clear     (clear),
        .out       (l_out),
        .out_valid (l_valid),
        .out_ready (out_ready),
        .overrun   (l_overrun),
        .nonzero   (l_nonzero)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake happens at the next rising edge whenever
    // out_valid & out_ready is seen here; the byte being consumed must be
    // the oldest one the stimulus pushed.
    always @(negedge clk) begin
        if (reset === 1'b0 && out_ready === 1'b1) begin
            if (m_valid === 1'b1) begin
                if (q_m.size() == 0) begin
                    chk("msb_unexpected_byte", m_out, 8'hxx);
                end else begin
                    logic [7:0] e;
                    e = q_m.pop_front();
                    chk("msb_consumed_byte", m_out, e);
                    chk("msb_consumed_nonzero", {7'd0, m_nonzero}, {7'd0, |e});
                end
            end
            if (l_valid === 1'b1) begin
                if (q_l.size() == 0) begin
                    chk("lsb_unexpected_byte", l_out, 8'hxx);
                end else begin
                    logic [7:0] e;
                    e = q_l.pop_front();
                    chk("lsb_consumed_byte", l_out, e);
                    chk("lsb_consumed_nonzero", {7'd0, l_nonzero}, {7'd0, |e});
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Send one byte; seq[7] is the first bit on the wire. exp_m/exp_l are
    // hand-computed results for each instance. When keep=1 the byte is
    // expected to land in the holding register and is queued for checking.
    // rdy_last drives out_ready during the completing strobe only.
    task automatic send_byte(input logic [7:0] seq, input logic [7:0] exp_m,
                             input logic [7:0] exp_l, input bit keep,
                             input bit rdy_last, input bit watch_valid);
        if (keep) begin
            q_m.push_back(exp_m);
            q_l.push_back(exp_l);
        end
        for (int i = 0; i < 8; i++) begin
            sin       = seq[7-i];
            sin_en    = 1'b1;
            out_ready = (i == 7) ? rdy_last : 1'b0;
            tick();
            if (watch_valid && i < 7) begin
                chk("valid_held", {7'd0, m_valid}, 8'd1);
            end
        end
        sin_en    = 1'b0;
        sin       = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic consume;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        sin       = 1'b0;
        sin_en    = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_out",       m_out,                  8'h00);
        chk("rst_valid",     {7'd0, m_valid},        8'd0);
        chk("rst_overrun",   {7'd0, m_overrun},      8'd0);
        chk("rst_nonzero",   {7'd0, m_nonzero},      8'd0);
        chk("rst_lsb_out",   l_out,                  8'h00);

        // 1,0,1,0,0,1,0,1 -> 0xA5 on both (palindromic)
        send_byte(8'hA5, 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0);
        chk("a5_out",     m_out,             8'hA5);
        chk("a5_valid",   {7'd0, m_valid},   8'd1);
        chk("a5_nonzero", {7'd0, m_nonzero}, 8'd1);
        consume();
        chk("a5_valid_after_hs", {7'd0, m_valid},   8'd0);
        chk("a5_stale_out",      m_out,             8'hA5);
        chk("a5_stale_nonzero",  {7'd0, m_nonzero}, 8'd1);

        // 1,1,0,0,0,0,0,0 -> MSB-first 0xC0, LSB-first 0x03
        send_byte(8'hC0, 8'hC0, 8'h03, 1'b1, 1'b0, 1'b0);
        chk("c0_msb_out", m_out, 8'hC0);
        chk("c0_lsb_out", l_out, 8'h03);
        consume();

        // Eight zeros -> 0x00, nonzero low
        send_byte(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("zero_out",         m_out,             8'h00);
        chk("zero_valid",       {7'd0, m_valid},   8'd1);
        chk("zero_nonzero",     {7'd0, m_nonzero}, 8'd0);
        chk("zero_lsb_nonzero", {7'd0, l_nonzero}, 8'd0);
        consume();

        // Overrun: 0x11 kept, 0x22 dropped
        send_byte(8'h11, 8'h11, 8'h88, 1'b1, 1'b0, 1'b0);
        send_byte(8'h22, 8'h22, 8'h44, 1'b0, 1'b0, 1'b0);
        chk("ovr_out",      m_out,             8'h11);
        chk("ovr_lsb_out",  l_out,             8'h88);
        chk("ovr_valid",    {7'd0, m_valid},   8'd1);
        chk("ovr_flag",     {7'd0, m_overrun}, 8'd1);
        consume();
        chk("ovr_valid_after_hs", {7'd0, m_valid},   8'd0);
        chk("ovr_sticky",         {7'd0, m_overrun}, 8'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("ovr_cleared", {7'd0, m_overrun}, 8'd0);

        // Completion coinciding with handshake: no bubble, direct reload
        send_byte(8'h01, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0);
        send_byte(8'h02, 8'h02, 8'h40, 1'b1, 1'b1, 1'b1);
        chk("b2b_valid",   {7'd0, m_valid},   8'd1);
        chk("b2b_out",     m_out,             8'h02);
        chk("b2b_overrun", {7'd0, m_overrun}, 8'd0);
        send_byte(8'h03, 8'h03, 8'hC0, 1'b1, 1'b1, 1'b1);
        chk("b2b_out3",     m_out,           8'h03);
        chk("b2b_lsb_out3", l_out,           8'hC0);
        chk("b2b_valid3",   {7'd0, m_valid}, 8'd1);
        consume();

        // Partial bits 0,1,0,1 then clear together with a strobe of 0
        for (int i = 0; i < 4; i++) begin
            sin    = i[0];
            sin_en = 1'b1;
            tick();
        end
        sin   = 1'b0;
        clear = 1'b1;
        tick();
        clear  = 1'b0;
        sin_en = 1'b0;
        send_byte(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        chk("clr_out",     m_out, 8'hFF);
        chk("clr_lsb_out", l_out, 8'hFF);
        consume();

        // Reset mid-byte with a full holding register and overrun set
        send_byte(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0);
        send_byte(8'h33, 8'h33, 8'hCC, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_overrun", {7'd0, m_overrun}, 8'd1);
        for (int i = 0; i < 3; i++) begin
            sin    = 1'b1;
            sin_en = 1'b1;
            tick();
        end
        sin_en = 1'b0;
        reset  = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_out",     m_out,             8'h00);
        chk("mid_rst_valid",   {7'd0, m_valid},   8'd0);
        chk("mid_rst_overrun", {7'd0, m_overrun}, 8'd0);
        chk("mid_rst_nonzero", {7'd0, m_nonzero}, 8'd0);
        // Counter restarted: next eight strobes form a fresh byte
        send_byte(8'h81, 8'h81, 8'h81, 1'b1, 1'b0, 1'b0);
        chk("post_rst_out", m_out, 8'h81);
        consume();

        tick();
        chk("queue_msb_empty", 8'(q_m.size()), 8'd0);
        chk("queue_lsb_empty", 8'(q_l.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_shift_in8
`default_nettype wire
